// File: rtl/q2f_conv_rr_scheduler_if.sv
// q2f_conv_rr_scheduler_if
// Request, converter and result signals of the shared Q2.30->float converter
// scheduler. "master" is the scheduler side, "slave" is the environment side
// (sine generators, converter, float consumer).
interface q2f_conv_rr_scheduler_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = 2
);
   logic [NUM_CH-1:0]    req_valid;
   logic [32*NUM_CH-1:0] req_data;
   logic [NUM_CH-1:0]    req_ready;
   logic [31:0]          conv_q_out;
   logic [31:0]          conv_float_in;
   logic                 res_valid;
   logic                 res_ready;
   logic [CH_W-1:0]      res_ch;
   logic [31:0]          res_data;

   modport master (
      input  req_valid, req_data, conv_float_in, res_ready,
      output req_ready, conv_q_out, res_valid, res_ch, res_data
   );

   modport slave (
      output req_valid, req_data, conv_float_in, res_ready,
      input  req_ready, conv_q_out, res_valid, res_ch, res_data
   );
endinterface

// File: rtl/q2f_conv_rr_scheduler.sv
// q2f_conv_rr_scheduler
// Shares one non-stallable Q2.30->float converter (CONV_LATENCY stages)
// between NUM_CH requesters. Round-robin grant, at most one issue per cycle;
// channel tags ride a delay line matched to the converter, results land in a
// show-ahead FIFO. Issue is credit-guarded so a converter result always finds
// a free FIFO slot regardless of consumer backpressure.
// Optional statistics (grant_cnt, stall_cnt): define Q2F_SCHED_STATS_EN.
module q2f_conv_rr_scheduler #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_W         = 2,
   parameter int unsigned CONV_LATENCY = 4,
   parameter int unsigned OUT_DEPTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   q2f_conv_rr_scheduler_if.master bus,
   output logic                    busy
`ifdef Q2F_SCHED_STATS_EN
   ,
   output logic [16*NUM_CH-1:0]    grant_cnt,
   output logic [15:0]             stall_cnt
`endif
);

   localparam int unsigned AW     = $clog2(OUT_DEPTH);
   localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);
   localparam int unsigned ENT_W  = CH_W + 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                run_en;

   logic [CH_W-1:0]     rr_ptr_q;
   logic [CRED_W-1:0]   credits_q;

   logic                hi_found, lo_found, win_found;
   logic [CH_W-1:0]     hi_ch, lo_ch, win_ch;
   logic [31:0]         win_data;
   logic                grant;
   logic [NUM_CH-1:0]   req_ready_c;

   logic [31:0]         conv_q_q;

   logic [CONV_LATENCY:0] tag_vld_q;
   logic [CH_W-1:0]       tag_ch_q [0:CONV_LATENCY];

   logic [ENT_W-1:0]    fifo_mem [OUT_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         count_q;
   logic                wr_en, pop, fifo_empty, fifo_full, pipe_empty;
   logic [ENT_W-1:0]    head;

   assign wr_en      = tag_vld_q[CONV_LATENCY];
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (AW+1)'(OUT_DEPTH));
   assign pop        = !fifo_empty && bus.res_ready;
   assign pipe_empty = !(|tag_vld_q) && fifo_empty;
   assign head       = fifo_mem[rd_ptr_q];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and state-derived outputs
   always_comb begin
      state_d = state_q;
      run_en  = 1'b0;
      busy    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            run_en = enable;
            if (!enable) state_d = pipe_empty ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enable)          state_d = ST_RUN;
            else if (pipe_empty) state_d = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Round-robin search: lowest requester at/above the pointer wins,
   // otherwise the lowest requester below it (wrap-around).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_ch    = '0;
      lo_ch    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (bus.req_valid[i]) begin
            if (CH_W'(i) >= rr_ptr_q) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_ch    = CH_W'(i);
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_ch    = CH_W'(i);
            end
         end
      end
      win_found = hi_found || lo_found;
      win_ch    = hi_found ? hi_ch : lo_ch;
   end

   // Grant qualification (registered credits only) and winner data mux
   always_comb begin
      grant       = run_en && (credits_q != '0) && win_found;
      req_ready_c = '0;
      win_data    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (CH_W'(i) == win_ch) begin
            req_ready_c[i] = grant;
            win_data       = bus.req_data[32*i +: 32];
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.conv_q_out = conv_q_q;

   // Converter input register: loads the winner sample, holds otherwise
   always_ff @(posedge clk) begin
      if (!rst_n)     conv_q_q <= '0;
      else if (grant) conv_q_q <= win_data;
   end

   // Round-robin pointer and output-slot credits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         credits_q <= CRED_W'(OUT_DEPTH);
      end else begin
         if (grant)
            rr_ptr_q <= (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + CH_W'(1);
         case ({grant, pop})
            2'b10:   credits_q <= credits_q - CRED_W'(1);
            2'b01:   credits_q <= credits_q + CRED_W'(1);
            default: credits_q <= credits_q;
         endcase
      end
   end

   // Tag delay line aligned to converter latency; cleared tags never write,
   // which is what discards converter contents across a reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_vld_q <= '0;
         for (int unsigned i = 0; i <= CONV_LATENCY; i++) tag_ch_q[i] <= '0;
      end else begin
         tag_vld_q   <= {tag_vld_q[CONV_LATENCY-1:0], grant};
         tag_ch_q[0] <= win_ch;
         for (int unsigned i = 1; i <= CONV_LATENCY; i++) tag_ch_q[i] <= tag_ch_q[i-1];
      end
   end

   // FIFO storage (no reset needed: occupancy tracked by pointers/count)
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= {tag_ch_q[CONV_LATENCY], bus.conv_float_in};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Show-ahead head; zero when empty so idle/reset outputs read as 0
   always_comb begin
      bus.res_valid = !fifo_empty;
      bus.res_ch    = fifo_empty ? '0 : head[ENT_W-1:32];
      bus.res_data  = fifo_empty ? '0 : head[31:0];
   end

`ifdef Q2F_SCHED_STATS_EN
   // Saturating per-channel grant counters and credit-stall counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant && (win_ch == CH_W'(i)) && (grant_cnt[16*i +: 16] != 16'hFFFF))
               grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
         end
         if ((state_q == ST_RUN) && (|bus.req_valid) && (credits_q == '0) &&
             (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

   wr_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && fifo_full));
   grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_q2f_conv_rr_scheduler.sv
// tb_q2f_conv_rr_scheduler
// Directed bench for q2f_conv_rr_scheduler with a behavioural 4-stage
// Q2.30->float converter model hooked to conv_q_out/conv_float_in.
module tb_q2f_conv_rr_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   logic busy;
`ifdef Q2F_SCHED_STATS_EN
   logic [63:0] grant_cnt;
   logic [15:0] stall_cnt;
`endif

   q2f_conv_rr_scheduler_if #(.NUM_CH(4), .CH_W(2)) bus_if ();

   q2f_conv_rr_scheduler #(
      .NUM_CH(4), .CH_W(2), .CONV_LATENCY(4), .OUT_DEPTH(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .bus    (bus_if),
      .busy   (busy)
`ifdef Q2F_SCHED_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Per-channel stimulus and hand-computed float results
   logic [31:0] in_tbl  [4] = '{32'hC000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000};
   logic [31:0] out_tbl [4] = '{32'hBF80_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000};

   logic [33:0] got_q [$];
   logic [33:0] exp_q [$];

   function automatic logic [31:0] q2f(input logic [31:0] q);
      logic        s;
      logic [31:0] m, norm;
      logic [23:0] mant;
      logic [7:0]  e;
      int          p;
      s = q[31];
      m = s ? (~q + 32'd1) : q;
      if (m == 32'd0) return 32'd0;
      p = 31;
      while (!m[p]) p--;
      norm = m << (31 - p);
      mant = {1'b0, norm[30:8]};
      e    = 8'(p + 97);
      if (norm[7] && ((|norm[6:0]) || norm[8])) mant = mant + 24'd1;
      if (mant[23]) begin
         mant = '0;
         e    = e + 8'd1;
      end
      return {s, e, mant[22:0]};
   endfunction

   // Converter model: samples q_in at the edge after grant, valid 4 edges later
   logic [31:0] cv_s1, cv_s2, cv_s3, cv_s4;
   always @(posedge clk) begin
      cv_s1 <= q2f(bus_if.conv_q_out);
      cv_s2 <= cv_s1;
      cv_s3 <= cv_s2;
      cv_s4 <= cv_s3;
   end
   assign bus_if.conv_float_in = cv_s4;

   // Record every accepted result just before the edge that pops it
   always @(negedge clk) begin
      if (rst_n && bus_if.res_valid && bus_if.res_ready)
         got_q.push_back({bus_if.res_ch, bus_if.res_data});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int ch);
      exp_q.push_back({2'(ch), out_tbl[ch]});
   endtask

   task automatic wait_results(input int n);
      int cyc = 0;
      while (got_q.size() < n && cyc < 60) begin
         step();
         cyc++;
      end
      repeat (3) step();
   endtask

   task automatic cmp_results(input string tag);
      chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk({tag, "_ch"}, 32'(got_q[i][33:32]), 32'(exp_q[i][33:32]));
         chk({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic single_req(input string tag, input int ch, input logic [31:0] din,
                             input logic [31:0] dout);
      int lat = 0;
      bus_if.req_data[32*ch +: 32] = din;
      bus_if.req_valid = 4'(1 << ch);
      #1;
      chk({tag, "_rdy"}, 32'(bus_if.req_ready), 32'(1 << ch));
      step();
      bus_if.req_valid = '0;
      #1;
      chk({tag, "_rdy_off"}, 32'(bus_if.req_ready), 32'd0);
      chk({tag, "_qout"}, bus_if.conv_q_out, din);
      while (!bus_if.res_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd5);
      chk({tag, "_ch"}, 32'(bus_if.res_ch), 32'(ch));
      chk({tag, "_data"}, bus_if.res_data, dout);
      step();
      chk({tag, "_popped"}, 32'(bus_if.res_valid), 32'd0);
      got_q.delete();
   endtask

   task automatic rr_run(input string tag, input int first_ch, input int n);
      int ch = first_ch;
      bus_if.req_valid = '1;
      for (int k = 0; k < n; k++) begin
         #1;
         chk({tag, "_rdy"}, 32'(bus_if.req_ready), 32'(1 << ch));
         push_exp(ch);
         step();
         ch = (ch + 1) % 4;
      end
      bus_if.req_valid = '0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stale;
      int   ch;
      rst_n            = 1'b0;
      enable           = 1'b0;
      bus_if.req_valid = '0;
      bus_if.req_data  = {in_tbl[3], in_tbl[2], in_tbl[1], in_tbl[0]};
      bus_if.res_ready = 1'b0;
      repeat (3) step();

      chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
      chk("rst_qout", bus_if.conv_q_out, 32'd0);
      chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
      chk("rst_res_ch", 32'(bus_if.res_ch), 32'd0);
      chk("rst_res_data", bus_if.res_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      rst_n            = 1'b1;
      enable           = 1'b1;
      bus_if.res_ready = 1'b1;
      step();
      chk("run_busy", 32'(busy), 32'd1);

      // Single request ch2 (+1.0), then zero sample on ch1
      single_req("one", 2, 32'h4000_0000, 32'h3F80_0000);
      single_req("zero", 1, 32'h0000_0000, 32'h0000_0000);
      bus_if.req_data[63:32] = in_tbl[1];

      // All channels valid, pointer at 2 after grant to ch1
      rr_run("rr", 2, 8);
      wait_results(8);
      cmp_results("rr_res");

      // Backpressure: exactly OUT_DEPTH grants then credit stall
      bus_if.res_ready = 1'b0;
      bus_if.req_valid = '1;
      ch = 2;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("bp_rdy", 32'(bus_if.req_ready), (k < 8) ? 32'(1 << ch) : 32'd0);
         if (k < 8) begin
            push_exp(ch);
            ch = (ch + 1) % 4;
         end
         step();
      end
      bus_if.req_valid = '0;
      repeat (4) step();
      chk("bp_head_valid", 32'(bus_if.res_valid), 32'd1);
      chk("bp_head_ch", 32'(bus_if.res_ch), 32'd2);
      chk("bp_head_data", bus_if.res_data, 32'h3F80_0000);
      repeat (2) step();
      chk("bp_hold_ch", 32'(bus_if.res_ch), 32'd2);
      chk("bp_hold_data", bus_if.res_data, 32'h3F80_0000);
      bus_if.res_ready = 1'b1;
      wait_results(8);
      cmp_results("bp_res");
      rr_run("resume", 2, 1);
      wait_results(1);
      cmp_results("resume_res");

      // Drain: three in flight when enable drops
      bus_if.req_valid = '1;
      push_exp(3);
      push_exp(0);
      push_exp(1);
      repeat (3) step();
      enable = 1'b0;
      #1;
      chk("drain_rdy_off", 32'(bus_if.req_ready), 32'd0);
      step();
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_rdy_hold", 32'(bus_if.req_ready), 32'd0);
      begin
         int cyc = 0;
         while (got_q.size() < 3 && cyc < 30) begin
            step();
            cyc++;
         end
         chk("drain_timeout", 32'(cyc < 30), 32'd1);
      end
      chk("drain_busy_last", 32'(busy), 32'd1);
      step();
      chk("drain_idle", 32'(busy), 32'd0);
      bus_if.req_valid = '0;
      repeat (3) step();
      cmp_results("drain_res");

      // Reset mid-stream: 4 in flight, 2 in FIFO
      bus_if.res_ready = 1'b0;
      enable           = 1'b1;
      step();
      bus_if.req_valid = '1;
      repeat (6) step();
      bus_if.req_valid = '0;
      step();
      chk("pre_rst_valid", 32'(bus_if.res_valid), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_req_ready", 32'(bus_if.req_ready), 32'd0);
      chk("mid_rst_qout", bus_if.conv_q_out, 32'd0);
      chk("mid_rst_res_valid", 32'(bus_if.res_valid), 32'd0);
      chk("mid_rst_res_ch", 32'(bus_if.res_ch), 32'd0);
      chk("mid_rst_res_data", bus_if.res_data, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      rst_n            = 1'b1;
      bus_if.res_ready = 1'b1;
      got_q.delete();
      exp_q.delete();
      stale = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus_if.res_valid) stale = 1'b1;
      end
      chk("no_stale", 32'(stale), 32'd0);
      chk("no_stale_cnt", 32'(got_q.size()), 32'd0);

      // Pointer back at 0 after reset: 0,1,2,3,0 with ch0 = -1.0
      rr_run("post_rst", 0, 5);
      wait_results(5);
      cmp_results("post_rst_res");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/q2f_conv_rr_scheduler.md
Name: q2f_conv_rr_scheduler

Overview:
- Shares one Q2.30-to-IEEE-754 single-precision converter (fixed 4-stage pipeline, no enable, no reset) between NUM_CH sine-channel requesters.
- Round-robin grant, one conversion issued per cycle max; channel tags travel alongside the converter latency.
- Results land in an output FIFO with credit-based issue, so downstream backpressure never overruns the non-stallable converter.
- Sits between the per-channel sine generators and the float consumer (DAC formatter / AXI-stream packer).

Parameters:
NUM_CH, 4, number of requesters (2..8)
CH_W, 2, channel-id width, must be >= clog2(NUM_CH)
CONV_LATENCY, 4, converter register stages from q_in sample to float_out valid
OUT_DEPTH, 8, output FIFO entries (power of 2, >= CONV_LATENCY+1)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  synchronous reset, active-low
enable  in  1  1 = grants allowed; 0 = stop granting, drain in-flight work
req_valid  in  NUM_CH  per-channel request
req_data  in  32*NUM_CH  Q2.30 samples, channel i at [32i+31:32i]
req_ready  out  NUM_CH  one-hot grant; transfer when req_valid[i]&req_ready[i]
conv_q_out  out  32  registered sample to converter q_in
conv_float_in  in  32  converter float_out
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accept
res_ch  out  CH_W  channel id of head
res_data  out  32  float of head
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at an edge): req_ready=0, conv_q_out=0, res_valid=0, res_ch=0, res_data=0, busy=0, rr pointer=0, credits=OUT_DEPTH, tag pipe cleared, FIFO empty, state=IDLE. Converter contents at reset are discarded, because cleared tags never write.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0 and (tags in flight or FIFO non-empty).
  - RUN -> IDLE when enable=0 and all empty.
  - DRAIN -> RUN when enable=1.
  - DRAIN -> IDLE when tag pipe and FIFO are both empty.
- Grant logic is combinational:
  - Eligible only in RUN with enable=1 and credits>0.
  - Winner is the first i with req_valid[i]=1, searching from rr pointer upward and wrapping.
  - req_ready is one-hot or zero.
- On grant edge G:
  - conv_q_out <= winner data.
  - Tag {1,ch} enters tag stage 0.
  - rr pointer <= (ch+1) mod NUM_CH.
  - credits decrement.
- No grant at an edge: conv_q_out holds its value; tag stage 0 <= invalid.
- Tag delay line has CONV_LATENCY+1 stages. The converter samples at G+1, so float_out is valid after edge G+CONV_LATENCY. The FIFO writes {ch, conv_float_in} at edge G+CONV_LATENCY+1.
- Minimum grant-to-res_valid latency = CONV_LATENCY+1 cycles (5 at default), with an empty FIFO.
- FIFO is show-ahead; res_* are driven from the head.
  - Pop on res_valid&res_ready; credits increment.
  - Simultaneous grant and pop leaves credits unchanged.
  - Credits reserve slots at grant time, so a FIFO write always finds a free slot. Write to a full FIFO is impossible by construction; assert in sim.
- Credit rules:
  - credits == 0 -> no grants, even with pending requests.
  - A pop at the same edge does not enable a same-cycle grant (grant uses registered credits).
- Ordering: results exit in grant order; per-channel order preserved.
- res_data/res_ch hold stable while res_valid=1 and res_ready=0.
- Reset mid-operation: everything returns to reset values at that edge; in-flight samples are lost and never appear on res_*.
- Pointer wrap: after a grant to channel NUM_CH-1, the pointer becomes 0.

Optional Feature:
- Macro Q2F_SCHED_STATS_EN.
- When defined, the block adds:
  - output port grant_cnt (16*NUM_CH): per-channel saturating 16-bit grant counters; they stop at 0xFFFF.
  - output port stall_cnt (16): saturating count of cycles with any req_valid=1 in RUN while credits=0.
  - All counters reset to 0 on rst_n=0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: enable=1, ch2 valid with 0x40000000 (+1.0), res_ready=1 -> req_ready=4'b0100 one cycle. Exactly 5 cycles later res_valid=1, res_ch=2, res_data=0x3F800000.
- All four channels held valid with res_ready=1 -> grants 0,1,2,3,0,1… one per cycle. res_ch follows the same order; ch0 sends 0xC0000000 (-1.0) -> 0xBF800000.
- res_ready=0, all channels valid -> exactly OUT_DEPTH=8 grants, then req_ready=0 and credits=0. Release res_ready -> 8 results in order, then grants resume; no loss or duplication.
- Drain: deassert enable with 3 in flight -> state DRAIN, no new req_ready, busy=1. After the 3 results are popped, busy=0 next cycle.
- Reset mid-stream: rst_n=0 for one edge with 4 in flight and 2 in FIFO -> all outputs at reset values. No stale result appears within 10 cycles after rst_n=1 with no requests.
- Zero sample: ch1 sends 0x00000000 -> res_data=0x00000000, res_ch=1, latency 5 cycles.
